// File: rtl/collision_detect_if.sv
// Bus bundle between the ball-mover side and collision_detect.
//   master : drives the tick/level strobes and the ball/paddle state,
//            receives the collision pulses, brick map and status.
//   slave  : the collision_detect side of the same signals.
interface collision_detect_if;
  logic        tick;
  logic        start_level;
  logic [7:0]  ballX;
  logic [7:0]  ballY;
  logic        dirX;
  logic        dirY;
  logic [2:0]  speed;
  logic [7:0]  paddleX;
  logic        cX;
  logic        cY;
  logic        cBrickX;
  logic        cBrickY;
  logic [4:0]  hit_idx;
  logic [31:0] bricks;
  logic [5:0]  bricks_left;
  logic        level_clear;
  logic        ball_lost;
  logic        busy;
  logic        done;

  modport master (
    output tick, start_level, ballX, ballY, dirX, dirY, speed, paddleX,
    input  cX, cY, cBrickX, cBrickY, hit_idx, bricks, bricks_left,
           level_clear, ball_lost, busy, done
  );

  modport slave (
    input  tick, start_level, ballX, ballY, dirX, dirY, speed, paddleX,
    output cX, cY, cBrickX, cBrickY, hit_idx, bricks, bricks_left,
           level_clear, ball_lost, busy, done
  );
endinterface

// File: rtl/collision_detect.sv
// collision_detect: per ball-step collision engine for the brick game.
// On an accepted tick it predicts the next ball position, checks walls and
// paddle, scans the brick map one brick per cycle, then reports one-cycle
// collision pulses together with done and clears the brick that was hit.
// Ports:
//   clock  : system clock
//   reset  : asynchronous, active-high reset
//   bus    : collision_detect_if.slave (strobes, ball/paddle state in;
//            collision pulses, brick map, counts and status out)
//
// state   | meaning
// IDLE    | waiting for tick; ball inputs latched on acceptance
// PREDICT | next position computed, wall/paddle results registered
// SCAN    | one brick tested per cycle, first alive overlap latched
// REPORT  | done + collision pulses; hit brick cleared at end of cycle
module collision_detect #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int BALL_SZ    = 2,
  parameter int PADDLE_Y   = 110,
  parameter int PADDLE_W   = 16,
  parameter int BRICK_COLS = 8,
  parameter int BRICK_ROWS = 4,
  parameter int BRICK_W    = 20,
  parameter int BRICK_H    = 6,
  parameter int BRICK_TOP  = 10
) (
  input  logic              clock,
  input  logic              reset,
  collision_detect_if.slave bus
);

  localparam int N = BRICK_ROWS * BRICK_COLS;
  localparam logic [31:0] ALL_ALIVE = 32'((64'd1 << N) - 64'd1);

  typedef enum logic [1:0] {IDLE, PREDICT, SCAN, REPORT} state_t;

  state_t state_q, state_d;

  logic [7:0]        bx_q, by_q, px_q;
  logic              dx_q, dy_q;
  logic [2:0]        spd_q;
  logic signed [8:0] nx_q, ny_q;
  logic              cx_q, cy_q, lost_q;
  logic              hit_q, face_y_q;
  logic [4:0]        hit_idx_q, idx_q;
  logic [31:0]       bricks_q;
  logic [5:0]        left_q;

  logic signed [8:0] nx_c, ny_c;
  logic              cx_c, cy_c, lost_c, paddle_c;
  logic              overlap_c, face_y_c;
  int                nx_i, ny_i, px_i, snx_i, sny_i, col_i, row_i, bxl_i, byl_i, bx_i;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.tick) state_d = PREDICT;
      PREDICT: state_d = SCAN;
      SCAN:    if (idx_q == 5'(N - 1)) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // start_level aborts anything in flight, including a same-cycle tick
    if (bus.start_level) state_d = IDLE;
  end

  // Next-position prediction and wall/paddle rules (used in PREDICT).
  // 9-bit wrap arithmetic yields the signed result for on-screen inputs.
  always_comb begin
    nx_c     = dx_q ? (9'(bx_q) - 9'(spd_q)) : (9'(bx_q) + 9'(spd_q));
    ny_c     = dy_q ? (9'(by_q) - 9'(spd_q)) : (9'(by_q) + 9'(spd_q));
    nx_i     = int'(nx_c);
    ny_i     = int'(ny_c);
    px_i     = int'(px_q);
    cx_c     = (dx_q && nx_i <= 0) || (!dx_q && nx_i >= SCREEN_W - BALL_SZ);
    paddle_c = !dy_q && (ny_i + BALL_SZ >= PADDLE_Y) && (ny_i < PADDLE_Y + 2) &&
               (nx_i <= px_i + PADDLE_W - 1) && (nx_i + BALL_SZ - 1 >= px_i);
    cy_c     = (dy_q && ny_i <= 0) || paddle_c;
    lost_c   = !dy_q && (ny_i >= SCREEN_H - BALL_SZ) && !paddle_c;
  end

  // Brick test for the current scan index against the registered next box.
  always_comb begin
    snx_i     = int'(nx_q);
    sny_i     = int'(ny_q);
    bx_i      = int'(bx_q);
    col_i     = int'(idx_q) % BRICK_COLS;
    row_i     = int'(idx_q) / BRICK_COLS;
    bxl_i     = col_i * BRICK_W;
    byl_i     = BRICK_TOP + row_i * BRICK_H;
    overlap_c = bricks_q[idx_q] &&
                (snx_i <= bxl_i + BRICK_W - 1) && (snx_i + BALL_SZ - 1 >= bxl_i) &&
                (sny_i <= byl_i + BRICK_H - 1) && (sny_i + BALL_SZ - 1 >= byl_i);
    // Ball already within the brick's columns -> it came through a top/bottom face
    face_y_c  = (bx_i <= bxl_i + BRICK_W - 1) && (bx_i + BALL_SZ - 1 >= bxl_i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bx_q      <= '0;
      by_q      <= '0;
      px_q      <= '0;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      spd_q     <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      cx_q      <= 1'b0;
      cy_q      <= 1'b0;
      lost_q    <= 1'b0;
      hit_q     <= 1'b0;
      face_y_q  <= 1'b0;
      hit_idx_q <= '0;
      idx_q     <= '0;
      bricks_q  <= ALL_ALIVE;
      left_q    <= 6'(N);
    end else if (bus.start_level) begin
      bricks_q <= ALL_ALIVE;
      left_q   <= 6'(N);
      hit_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tick) begin
            bx_q  <= bus.ballX;
            by_q  <= bus.ballY;
            px_q  <= bus.paddleX;
            dx_q  <= bus.dirX;
            dy_q  <= bus.dirY;
            spd_q <= bus.speed;
          end
        end
        PREDICT: begin
          nx_q   <= nx_c;
          ny_q   <= ny_c;
          cx_q   <= cx_c;
          cy_q   <= cy_c;
          lost_q <= lost_c;
          hit_q  <= 1'b0;
          idx_q  <= '0;
        end
        SCAN: begin
          if (!hit_q && overlap_c) begin
            hit_q     <= 1'b1;
            hit_idx_q <= idx_q;
            face_y_q  <= face_y_c;
          end
          idx_q <= idx_q + 5'd1;
        end
        REPORT: begin
          if (hit_q) begin
            bricks_q[hit_idx_q] <= 1'b0;
            left_q              <= left_q - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic report;
  assign report          = (state_q == REPORT);
  assign bus.done        = report;
  assign bus.busy        = (state_q != IDLE);
  assign bus.cX          = report & cx_q;
  assign bus.cY          = report & cy_q;
  assign bus.ball_lost   = report & lost_q;
  assign bus.cBrickX     = report & hit_q & ~face_y_q;
  assign bus.cBrickY     = report & hit_q & face_y_q;
  assign bus.hit_idx     = hit_idx_q;
  assign bus.bricks      = bricks_q;
  assign bus.bricks_left = left_q;
  assign bus.level_clear = (left_q == 6'd0);

endmodule

// File: tb/tb_collision_detect.sv
module tb_collision_detect;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  collision_detect_if bus ();
  collision_detect dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       cx, cy, cbx, cby, lost;
    logic [4:0] idx;
  } res_t;

  res_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_bricks;
  int          m_left;

  // Reference model of one ball step against the model brick map.
  function automatic res_t predict(int bx, int by, int dx, int dy, int sp, int px);
    res_t r;
    int nx, ny, lo_x, lo_y;
    logic pad;
    r  = '0;
    nx = dx ? bx - sp : bx + sp;
    ny = dy ? by - sp : by + sp;
    r.cx = (dx != 0 && nx <= 0) || (dx == 0 && nx >= 158);
    pad  = (dy == 0) && (ny + 2 >= 110) && (ny < 112) && (nx + 1 >= px) && (nx <= px + 15);
    r.cy = (dy != 0 && ny <= 0) || pad;
    r.lost = (dy == 0) && (ny >= 118) && !pad;
    for (int i = 0; i < 32; i++) begin
      lo_x = (i % 8) * 20;
      lo_y = 10 + (i / 8) * 6;
      if (!(r.cbx || r.cby) && m_bricks[i] &&
          nx + 1 >= lo_x && nx <= lo_x + 19 && ny + 1 >= lo_y && ny <= lo_y + 5) begin
        r.idx = 5'(i);
        if (bx + 1 >= lo_x && bx <= lo_x + 19) r.cby = 1'b1;
        else                                   r.cbx = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic run_tick(input int bx, input int by, input int dx, input int dy,
                          input int sp, input int px, output res_t obs, output int lat);
    res_t e;
    e = predict(bx, by, dx, dy, sp, px);
    if (e.cbx || e.cby) begin
      m_bricks[e.idx] = 1'b0;
      m_left--;
    end
    sb.push_back(e);
    @(negedge clock);
    bus.ballX = 8'(bx); bus.ballY = 8'(by);
    bus.dirX = 1'(dx);  bus.dirY = 1'(dy);
    bus.speed = 3'(sp); bus.paddleX = 8'(px);
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    obs = {bus.cX, bus.cY, bus.cBrickX, bus.cBrickY, bus.ball_lost,
           (bus.cBrickX | bus.cBrickY) ? bus.hit_idx : 5'd0};
  endtask

  task automatic pulse_start_level();
    @(negedge clock);
    bus.start_level = 1'b1;
    m_bricks = 32'hFFFF_FFFF;
    m_left   = 32;
    @(negedge clock);
    bus.start_level = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done); end
    total++; if (bus.bricks !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_bricks: got %h want ffffffff", bus.bricks); end
    total++; if (bus.bricks_left !== 6'd32) begin bad++; $display("FAIL reset_left: got %0d want 32", bus.bricks_left); end
    total++; if (bus.level_clear !== 1'b0 || bus.hit_idx !== 5'd0) begin bad++; $display("FAIL reset_flags: lc=%b idx=%0d want 0 0", bus.level_clear, bus.hit_idx); end
    total++; if ({bus.cX, bus.cY, bus.cBrickX, bus.cBrickY, bus.ball_lost} !== 5'b0) begin bad++; $display("FAIL reset_pulses: got %b want 00000", {bus.cX, bus.cY, bus.cBrickX, bus.cBrickY, bus.ball_lost}); end
  endtask

  task automatic test_basic();
    res_t o, e;
    int lat;
    // free flight, side wall, brick hit, speed-0 wall, corner
    int v [5][6] = '{'{80, 60, 0, 0, 1, 0}, '{159, 60, 0, 0, 1, 0}, '{25, 30, 0, 1, 2, 0},
                     '{158, 60, 0, 0, 0, 0}, '{1, 1, 1, 1, 2, 0}};
    for (int k = 0; k < 5; k++) begin
      run_tick(v[k][0], v[k][1], v[k][2], v[k][3], v[k][4], v[k][5], o, lat);
      e = sb.pop_front();
      total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want 34", k, lat); end
      total++; if (o !== e) begin bad++; $display("FAIL basic_result[%0d]: got %h want %h", k, o, e); end
      @(negedge clock);
      total++; if (bus.bricks_left !== 6'(m_left) || bus.bricks !== m_bricks) begin bad++; $display("FAIL basic_map[%0d]: got %0d/%h want %0d/%h", k, bus.bricks_left, bus.bricks, m_left, m_bricks); end
    end
    total++; if (bus.bricks[25] !== 1'b0 || bus.bricks_left !== 6'd31) begin bad++; $display("FAIL brick25_cleared: got bit=%b left=%0d want 0 31", bus.bricks[25], bus.bricks_left); end
  endtask

  task automatic test_paddle();
    res_t o, e;
    int lat;
    run_tick(100, 108, 0, 0, 1, 95, o, lat);
    e = sb.pop_front();
    total++; if (o !== e || o.cy !== 1'b1) begin bad++; $display("FAIL paddle_hit: got %h want %h", o, e); end
    run_tick(100, 117, 0, 0, 1, 10, o, lat);
    e = sb.pop_front();
    total++; if (o !== e || o.lost !== 1'b1 || o.cy !== 1'b0) begin bad++; $display("FAIL ball_lost: got %h want %h", o, e); end
  endtask

  task automatic test_level_clear();
    res_t o, e;
    int lat;
    int nbad;
    pulse_start_level();
    nbad = 0;
    for (int i = 0; i < 32; i++) begin
      run_tick((i % 8) * 20 + 9, 10 + (i / 8) * 6 + 2, 0, 0, 0, 0, o, lat);
      e = sb.pop_front();
      total++; if (o !== e || lat !== 34) begin bad++; nbad++; if (nbad < 5) $display("FAIL clear_hit[%0d]: got %h lat=%0d want %h lat=34", i, o, lat, e); end
    end
    @(negedge clock);
    total++; if (bus.bricks_left !== 6'd0 || bus.level_clear !== 1'b1 || bus.bricks !== 32'h0) begin bad++; $display("FAIL level_clear_set: got left=%0d lc=%b map=%h want 0 1 0", bus.bricks_left, bus.level_clear, bus.bricks); end
    run_tick(159, 60, 0, 0, 1, 0, o, lat);
    e = sb.pop_front();
    total++; if (o !== e || bus.level_clear !== 1'b1) begin bad++; $display("FAIL wall_after_clear: got %h lc=%b want %h lc=1", o, bus.level_clear, e); end
    pulse_start_level();
    total++; if (bus.bricks !== 32'hFFFF_FFFF || bus.bricks_left !== 6'd32 || bus.level_clear !== 1'b0) begin bad++; $display("FAIL reload: got %h/%0d/%b want ffffffff/32/0", bus.bricks, bus.bricks_left, bus.level_clear); end
  endtask

  task automatic test_abort();
    int dones;
    @(negedge clock);
    bus.ballX = 8'd25; bus.ballY = 8'd30; bus.dirX = 1'b0; bus.dirY = 1'b1; bus.speed = 3'd2;
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    repeat (5) @(negedge clock);
    bus.start_level = 1'b1;
    @(negedge clock);
    bus.start_level = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    dones = 0;
    repeat (50) begin
      if (bus.done || bus.cBrickX || bus.cBrickY) dones++;
      @(negedge clock);
    end
    total++; if (dones !== 0 || bus.bricks !== 32'hFFFF_FFFF) begin bad++; $display("FAIL abort_no_done: got dones=%0d map=%h want 0 ffffffff", dones, bus.bricks); end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    int dones, cyc, first;
    sb.push_back(predict(80, 60, 0, 0, 1, 0));
    @(negedge clock);
    bus.ballX = 8'd80; bus.ballY = 8'd60; bus.dirX = 1'b0; bus.dirY = 1'b0; bus.speed = 3'd1; bus.paddleX = 8'd0;
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    dones = 0; first = 0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (cyc == 3) bus.tick = 1'b1;
      if (cyc == 4) bus.tick = 1'b0;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          first = cyc;
          o = {bus.cX, bus.cY, bus.cBrickX, bus.cBrickY, bus.ball_lost, 5'd0};
          e = sb.pop_front();
          total++; if (o !== e) begin bad++; $display("FAIL b2b_result: got %h want %h", o, e); end
        end
      end
      @(negedge clock);
    end
    total++; if (dones !== 1 || first !== 34) begin bad++; $display("FAIL b2b_dones: got count=%0d at=%0d want 1 at 34", dones, first); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bricks !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_mid: got busy=%b done=%b map=%h want 0 0 ffffffff", bus.busy, bus.done, bus.bricks); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.start_level = 1'b0;
    bus.ballX = '0; bus.ballY = '0; bus.dirX = 1'b0; bus.dirY = 1'b0;
    bus.speed = '0; bus.paddleX = '0;
    m_bricks = 32'hFFFF_FFFF;
    m_left   = 32;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_paddle();
    test_level_clear();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
